// File: rtl/kdf_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kdf_iter_ctrl
// Purpose  : Iterated key-derivation controller. For each of BLOCKS output
//            blocks it drives an external hash core `count` times. The first
//            message of a block is {password, salt, block_index}. Every later
//            message is the previous digest U, zero-extended. The per-block
//            result T is either the last digest (chain mode) or the XOR of
//            all digests (PBKDF2-style accumulate mode). T is then written
//            into its N-bit slot of key_derivated.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            start, mode         - request pulse; 0 = chain, 1 = XOR-accumulate
//            salt, user_password - key material, latched on an accepted start
//            count               - iterations per block (0 is treated as 1)
//            busy, done          - activity flag; one-cycle completion pulse
//            key_derivated       - BLOCKS*N-bit derived key
//            hash_start/hash_msg - one-cycle request and message to hash core
//            hash_done/hash_digest - completion strobe and digest from core
// Revision : 1.0 - initial release
// ============================================================================
module kdf_iter_ctrl #(
  parameter int N           = 128,
  parameter int SALT_WIDTH  = 64,
  parameter int PSW_WIDTH   = 80,
  parameter int COUNT_WIDTH = 32,
  parameter int BLOCKS      = 2,
  parameter int IDX_WIDTH   = 8,
  localparam int KEY_WIDTH  = BLOCKS * N,
  localparam int MSG_WIDTH  = PSW_WIDTH + SALT_WIDTH + IDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [SALT_WIDTH-1:0]  salt,
  input  logic [PSW_WIDTH-1:0]   user_password,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done,
  output logic [KEY_WIDTH-1:0]   key_derivated,
  output logic                   hash_start,
  output logic [MSG_WIDTH-1:0]   hash_msg,
  input  logic                   hash_done,
  input  logic [N-1:0]           hash_digest
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  // A digest must fit into the message so later iterations can feed U back.
  generate
    if (MSG_WIDTH < N) begin : g_msg_width_chk
      $error("kdf_iter_ctrl: MSG_WIDTH must be >= N");
    end
    // Block indices run 1..BLOCKS and must be representable in IDX_WIDTH bits.
    if (BLOCKS >= (2 ** IDX_WIDTH)) begin : g_blocks_chk
      $error("kdf_iter_ctrl: BLOCKS must be < 2**IDX_WIDTH");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                 state_q,      state_d;
  logic                   busy_q,       busy_d;
  logic                   done_q,       done_d;
  logic                   hash_start_q, hash_start_d;
  logic [KEY_WIDTH-1:0]   key_q,        key_d;
  logic [N-1:0]           u_q,          u_d;
  logic [N-1:0]           t_q,          t_d;
  logic [COUNT_WIDTH-1:0] iter_q,       iter_d;
  logic [IDX_WIDTH-1:0]   idx_q,        idx_d;
  logic [SALT_WIDTH-1:0]  salt_q,       salt_d;
  logic [PSW_WIDTH-1:0]   psw_q,        psw_d;
  logic [COUNT_WIDTH-1:0] count_q,      count_d;
  logic                   mode_q,       mode_d;

  logic [COUNT_WIDTH-1:0] w_iter_inc;
  logic [N-1:0]           w_t_next;

  // Iteration counter after the current hash is accounted for. iter_q never
  // exceeds count_q-1, so the increment cannot wrap.
  assign w_iter_inc = iter_q + COUNT_WIDTH'(1);

  // First digest of a block seeds T; later ones either replace it (chain)
  // or fold into it (accumulate).
  assign w_t_next = ((iter_q == '0) || !mode_q) ? u_q : (t_q ^ u_q);

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    hash_start_d = 1'b0;
    key_d        = key_q;
    u_d          = u_q;
    t_d          = t_q;
    iter_d       = iter_q;
    idx_d        = idx_q;
    salt_d       = salt_q;
    psw_d        = psw_q;
    count_d      = count_q;
    mode_d       = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          salt_d       = salt;
          psw_d        = user_password;
          // Zero iterations would never produce a digest; run one instead.
          count_d      = (count == '0) ? COUNT_WIDTH'(1) : count;
          mode_d       = mode;
          idx_d        = IDX_WIDTH'(1);
          iter_d       = '0;
          key_d        = '0;
          busy_d       = 1'b1;
          // Raised here so the pulse coincides with the REQ cycle.
          hash_start_d = 1'b1;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (hash_done) begin
          u_d     = hash_digest;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        t_d = w_t_next;
        if (w_iter_inc < count_q) begin
          iter_d       = w_iter_inc;
          hash_start_d = 1'b1;
          state_d      = S_REQ;
        end else begin
          // Block complete: drop T into slot idx-1.
          for (int b = 0; b < BLOCKS; b++) begin
            if (idx_q == IDX_WIDTH'(b + 1)) begin
              key_d[b*N +: N] = w_t_next;
            end
          end
          idx_d  = idx_q + IDX_WIDTH'(1);
          iter_d = '0;
          if (idx_q < IDX_WIDTH'(BLOCKS)) begin
            hash_start_d = 1'b1;
            state_d      = S_REQ;
          end else begin
            // done is registered, so it is high for exactly the FIN cycle.
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hash_start_q <= 1'b0;
      key_q        <= '0;
      u_q          <= '0;
      t_q          <= '0;
      iter_q       <= '0;
      idx_q        <= '0;
      salt_q       <= '0;
      psw_q        <= '0;
      count_q      <= '0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hash_start_q <= hash_start_d;
      key_q        <= key_d;
      u_q          <= u_d;
      t_q          <= t_d;
      iter_q       <= iter_d;
      idx_q        <= idx_d;
      salt_q       <= salt_d;
      psw_q        <= psw_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy          = busy_q;
  assign done          = done_q;
  assign hash_start    = hash_start_q;
  assign key_derivated = key_q;

  // The message depends only on registers that stay frozen from REQ until the
  // digest is captured at the end of WAIT, so it is stable over the request.
  assign hash_msg = (iter_q == '0) ? {psw_q, salt_q, idx_q}
                                   : MSG_WIDTH'(u_q);

endmodule
`default_nettype wire

// File: doc/kdf_iter_ctrl.md
KDF_ITER_CTRL -- requirements
Module: kdf_iter_ctrl

Interface
REQ-001 SHALL have parameter N, default 128, the hash digest width in bits.
REQ-002 SHALL have parameter SALT_WIDTH, default 64, the salt width.
REQ-003 SHALL have parameter PSW_WIDTH, default 80, the password width.
REQ-004 SHALL have parameter COUNT_WIDTH, default 32, the iteration-count width.
REQ-005 SHALL have parameter BLOCKS, default 2, the number of N-bit output blocks; the key width is KEY_WIDTH = BLOCKS*N.
REQ-006 SHALL have parameter IDX_WIDTH, default 8, the block-index width; MSG_WIDTH = PSW_WIDTH+SALT_WIDTH+IDX_WIDTH, and MSG_WIDTH >= N SHALL be asserted at elaboration.
REQ-007 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-008 SHALL have ports: start in 1, request pulse; mode in 1, 0 = chain (last digest), 1 = XOR-accumulate (PBKDF2-style).
REQ-009 SHALL have ports: salt in SALT_WIDTH; user_password in PSW_WIDTH; count in COUNT_WIDTH, iterations per block.
REQ-010 SHALL have ports: busy out 1; done out 1, one-cycle completion pulse; key_derivated out KEY_WIDTH.
REQ-011 SHALL have ports: hash_start out 1, one-cycle request to the hash core; hash_msg out MSG_WIDTH; hash_done in 1; hash_digest in N.

Function
REQ-012 SHALL implement the states IDLE, REQ, WAIT, ACCUM and FIN.
REQ-013 In IDLE, start=1 SHALL latch salt, user_password, count and mode, clear the block index to 1, clear the iteration counter to 0, and enter REQ on the next edge; busy SHALL be 1 in every state except IDLE.
REQ-014 start SHALL be ignored while busy=1, and latched inputs SHALL NOT change until the next accepted start.
REQ-015 A latched count of 0 SHALL be treated as 1.
REQ-016 REQ SHALL assert hash_start for exactly one cycle and then go to WAIT; hash_msg SHALL be stable from REQ until hash_done is accepted.
REQ-017 For the first iteration of each block, hash_msg SHALL be {user_password, salt, block_index}; for later iterations it SHALL be the previous digest U zero-extended to MSG_WIDTH (U in the LSBs).
REQ-018 WAIT SHALL hold until hash_done=1, then capture hash_digest into U and go to ACCUM; hash_done SHALL be ignored in every other state.
REQ-019 ACCUM, iteration 1: T SHALL be set to the digest; iterations after 1: T SHALL become T^digest if mode=1, or the digest if mode=0; the iteration counter SHALL then increment.
REQ-020 If the incremented counter is below count, ACCUM SHALL go to REQ.
REQ-021 If the incremented counter equals count, ACCUM SHALL write T into key_derivated[(idx-1)*N +: N], increment idx and reset the counter; it SHALL go to REQ if idx < BLOCKS, otherwise to FIN.
REQ-022 FIN SHALL pulse done for one cycle and then return to IDLE; key_derivated SHALL hold its value until the next accepted start.
REQ-023 key_derivated SHALL be cleared to 0 when a start is accepted.
REQ-024 Per-hash overhead SHALL be 2 cycles (REQ and ACCUM) plus the core latency; total latency SHALL be BLOCKS*count*(2+L)+1 cycles from the start edge to done, where L is the number of cycles from hash_start to hash_done.
REQ-025 The block index SHALL be IDX_WIDTH bits, and BLOCKS < 2**IDX_WIDTH SHALL be asserted at elaboration.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE and clear busy, done, hash_start, key_derivated, U, T, the iteration counter and idx to 0.
REQ-027 A reset asserted mid-operation SHALL abort the operation with no done pulse; a hash_done arriving after release SHALL be ignored because the block is in IDLE.

Verification
Use a hash model with L=3 and digest = msg[N-1:0] + 1 (mod 2**N).
REQ-028 BLOCKS=1, count=1, mode=0 -> one hash_start; done asserts 6 cycles after start; key_derivated = {psw,salt,8'h01}[127:0]+1.
REQ-029 BLOCKS=1, count=3, mode=1, initial message low bits = M -> key_derivated = (M+1)^(M+2)^(M+3); exactly 3 hash_start pulses.
REQ-030 BLOCKS=2, count=2, mode=0 -> the block index in the first message of each block is 1 then 2; the upper N bits are filled only after the lower; 4 hash requests in total.
REQ-031 count=0 -> behaves identically to count=1; start pulsed while busy -> no effect, no extra hash_start.
REQ-032 rst asserted while in WAIT, then hash_done pulsed after release -> busy=0, done never asserts, key_derivated = 0.
REQ-033 hash_done held high outside WAIT (IDLE, REQ) -> no state change other than the normal progression.
